// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: Moore strobes from state; PCWrite/PCSrc also follow MemReady/Zero.
// Latency: R-type 4, CBZ 3, LDUR 5+N, STUR 4+N cycles (N = MemReady wait cycles).
// Backpressure: MEM_RD/MEM_WR hold until MemReady; optional CBNZ under `ifdef CBNZ_SUPPORT_EN.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] Op,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        Reg2Loc,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [1:0]  ALUOp,
    output logic        Illegal
);

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_ADDR   = 4'd3,
        S_MEM_RD = 4'd4,
        S_MEM_WR = 4'd5,
        S_WB_R   = 4'd6,
        S_WB_LD  = 4'd7,
        S_BRANCH = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t state_q, state_d;

    logic is_ldur, is_stur, is_rtype, is_cbz;
    assign is_ldur  = (Op == OP_LDUR);
    assign is_stur  = (Op == OP_STUR);
    assign is_rtype = (Op == OP_ADD) || (Op == OP_SUB) || (Op == OP_AND) || (Op == OP_ORR);
    assign is_cbz   = (Op[10:3] == OP_CBZ);

`ifdef CBNZ_SUPPORT_EN
    localparam logic [7:0] OP_CBNZ = 8'b10110101;
    logic is_cbnz;
    assign is_cbnz = (Op[10:3] == OP_CBNZ);
`endif

    // State register; reset parks the FSM in FETCH asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; MemReady only matters in the memory states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (is_ldur || is_stur)  state_d = S_ADDR;
                else if (is_rtype)       state_d = S_EXEC_R;
                else if (is_cbz)         state_d = S_BRANCH;
`ifdef CBNZ_SUPPORT_EN
                else if (is_cbnz)        state_d = S_BRANCH;
`endif
                else                     state_d = S_HALT;
            end
            S_EXEC_R: state_d = S_WB_R;
            S_WB_R:   state_d = S_FETCH;
            // Op is held stable past DECODE, so it still selects load vs store here.
            S_ADDR:   state_d = is_ldur ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: state_d = MemReady ? S_WB_LD : S_MEM_RD;
            S_WB_LD:  state_d = S_FETCH;
            S_MEM_WR: state_d = MemReady ? S_FETCH : S_MEM_WR;
            S_BRANCH: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode; reset gates every strobe so FETCH's IRWrite stays low while held.
    always_comb begin
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        Reg2Loc  = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUOp    = 2'b00;
        Illegal  = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH:  IRWrite = 1'b1;
                S_EXEC_R: ALUOp = 2'b10;
                S_WB_R: begin
                    RegWrite = 1'b1;
                    PCWrite  = 1'b1;
                    ALUOp    = 2'b10;
                end
                S_ADDR: begin
                    ALUSrc  = 1'b1;
                    Reg2Loc = is_stur;
                end
                S_MEM_RD: begin
                    MemRead = 1'b1;
                    ALUSrc  = 1'b1;
                end
                S_WB_LD: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    PCWrite  = 1'b1;
                end
                // The store retires in the cycle memory accepts it.
                S_MEM_WR: begin
                    MemWrite = 1'b1;
                    Reg2Loc  = 1'b1;
                    ALUSrc   = 1'b1;
                    PCWrite  = MemReady;
                end
                S_BRANCH: begin
                    Reg2Loc = 1'b1;
                    ALUOp   = 2'b01;
                    PCWrite = 1'b1;
`ifdef CBNZ_SUPPORT_EN
                    PCSrc   = is_cbnz ? ~Zero : Zero;
`else
                    PCSrc   = Zero;
`endif
                end
                S_HALT:   Illegal = 1'b1;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against a per-instruction trace model.
// Each instruction's expected output sequence is built from its class, Zero and memory wait count.
// Also covers reset during a memory wait, HALT stickiness, and CBNZ per CBNZ_SUPPORT_EN.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] Op = 11'd0;
    logic        Zero = 1'b0;
    logic        MemReady = 1'b0;
    logic        IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemtoReg, RegWrite;
    logic        MemRead, MemWrite, Illegal;
    logic [1:0]  ALUOp;

    int n_vec = 0;
    int n_err = 0;

    logic [11:0] exp_q[$];
    logic [11:0] got;

    localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_CBNZ = 4, C_ILL = 5;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .Reg2Loc(Reg2Loc),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .ALUOp(ALUOp), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    assign got = {IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemtoReg, RegWrite,
                  MemRead, MemWrite, ALUOp, Illegal};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, required finish before time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [11:0] act, input logic [11:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %03h expected %03h", tag, act, req);
        end
    endtask

    // Field order: IRWrite PCWrite PCSrc Reg2Loc ALUSrc MemtoReg RegWrite MemRead MemWrite ALUOp Illegal
    function automatic logic [11:0] mk(bit ir, bit pcw, bit pcs, bit r2l, bit asrc, bit m2r,
                                       bit rw, bit mr, bit mw, bit [1:0] aop, bit ill);
        return {ir, pcw, pcs, r2l, asrc, m2r, rw, mr, mw, aop, ill};
    endfunction

    function automatic int classify(input logic [10:0] op);
        if (op == 11'b11111000010) return C_LD;
        if (op == 11'b11111000000) return C_ST;
        if (op == 11'b10001011000 || op == 11'b11001011000 ||
            op == 11'b10001010000 || op == 11'b10101010000) return C_R;
        if (op[10:3] == 8'b10110100) return C_CBZ;
`ifdef CBNZ_SUPPORT_EN
        if (op[10:3] == 8'b10110101) return C_CBNZ;
`endif
        return C_ILL;
    endfunction

    // Expected per-cycle outputs for one instruction, starting at its FETCH cycle.
    function automatic void build_trace(input int cls, input bit z, input int n);
        exp_q.delete();
        exp_q.push_back(mk(1,0,0,0,0,0,0,0,0,2'b00,0));
        exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,2'b00,0));
        case (cls)
            C_R: begin
                exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,2'b10,0));
                exp_q.push_back(mk(0,1,0,0,0,0,1,0,0,2'b10,0));
            end
            C_LD: begin
                exp_q.push_back(mk(0,0,0,0,1,0,0,0,0,2'b00,0));
                for (int i = 0; i <= n; i++) exp_q.push_back(mk(0,0,0,0,1,0,0,1,0,2'b00,0));
                exp_q.push_back(mk(0,1,0,0,0,1,1,0,0,2'b00,0));
            end
            C_ST: begin
                exp_q.push_back(mk(0,0,0,1,1,0,0,0,0,2'b00,0));
                for (int i = 0; i < n; i++) exp_q.push_back(mk(0,0,0,1,1,0,0,0,1,2'b00,0));
                exp_q.push_back(mk(0,1,0,1,1,0,0,0,1,2'b00,0));
            end
            C_CBZ:  exp_q.push_back(mk(0,1,z,1,0,0,0,0,0,2'b01,0));
            C_CBNZ: exp_q.push_back(mk(0,1,~z,1,0,0,0,0,0,2'b01,0));
            default: for (int i = 0; i < 20; i++) exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,2'b00,1));
        endcase
    endfunction

    // Entered and left at posedge+1 with the DUT in FETCH.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset_async", got, 12'h000);
        @(posedge clk);
        @(negedge clk);
        check("reset_hold", got, 12'h000);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_instr(input logic [10:0] op, input bit z, input int n, input int abort_at);
        int cls;
        int len;
        cls = classify(op);
        build_trace(cls, z, n);
        len = exp_q.size();
        for (int k = 0; k < len; k++) begin
            Op = op;
            if ((cls == C_LD || cls == C_ST) && k >= 3 && k <= 3 + n)
                MemReady = (k == 3 + n);
            else
                MemReady = 1'($urandom_range(0, 1));
            if ((cls == C_CBZ || cls == C_CBNZ) && k == 2)
                Zero = z;
            else
                Zero = 1'($urandom_range(0, 1));
            @(negedge clk);
            check($sformatf("op%03h_c%0d", op, k), got, exp_q[k]);
            if (k == abort_at) begin
                #1;
                do_reset();
                return;
            end
            @(posedge clk);
            #1;
        end
        if (cls == C_ILL) do_reset();
    endtask

    function automatic logic [10:0] rand_op();
        int r;
        logic [10:0] v;
        r = $urandom_range(0, 19);
        case (r)
            0:  v = 11'b10001011000;
            1:  v = 11'b11001011000;
            2:  v = 11'b10001010000;
            3:  v = 11'b10101010000;
            4, 5, 6, 7:  v = 11'b11111000010;
            8, 9, 10:    v = 11'b11111000000;
            11, 12, 13:  v = {8'b10110100, 3'($urandom_range(0, 7))};
            14, 15:      v = {8'b10110101, 3'($urandom_range(0, 7))};
            16:          v = 11'($urandom);
            default:     v = 11'b10001011000;
        endcase
        return v;
    endfunction

    initial begin
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_init", got, 12'h000);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(11'b10001011000, 1'b0, 0, -1);   // ADD
        run_instr(11'b11111000010, 1'b0, 3, -1);   // LDUR, 3 wait cycles
        run_instr(11'b11111000000, 1'b0, 0, -1);   // STUR, immediate ready
        run_instr(11'b10110100101, 1'b1, 0, -1);   // CBZ taken
        run_instr(11'b10110100000, 1'b0, 0, -1);   // CBZ not taken
        run_instr(11'b10110101011, 1'b0, 0, -1);   // CBNZ
        run_instr(11'b11111111111, 1'b0, 0, -1);   // illegal -> HALT, then reset
        run_instr(11'b11111000010, 1'b0, 10, 5);   // reset during MEM_RD wait
        run_instr(11'b11111000000, 1'b0, 8, 6);    // reset during MEM_WR wait
        run_instr(11'b11001011000, 1'b0, 0, -1);   // SUB after reset

        for (int i = 0; i < 80; i++) begin
            run_instr(rand_op(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port Op  input  11  instruction opcode field from the instruction register; stable from DECODE until the next FETCH.
REQ-004 SHALL have port Zero  input  1  ALU zero flag.
REQ-005 SHALL have port MemReady  input  1  data memory completion for the current read or write.
REQ-006 SHALL have outputs IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite  output  1 each  datapath strobes and selects.
REQ-007 SHALL have port ALUOp  output  2  ALU control class: 00 add, 01 pass/compare, 10 R-type funct.
REQ-008 SHALL have port Illegal  output  1  sticky unsupported-opcode flag.

Function
REQ-009 SHALL implement a Moore FSM with states FETCH, DECODE, EXEC_R, ADDR, MEM_RD, MEM_WR, WB_R, WB_LD, BRANCH, HALT; outputs derive from the state, except PCSrc and PCWrite, which also depend on Zero or MemReady as stated below.
REQ-010 SHALL drive every output not listed for a state to 0.
REQ-011 FETCH SHALL assert IRWrite and always go to DECODE.
REQ-012 DECODE SHALL assert no strobes and branch on Op.
- LDUR 11111000010 or STUR 11111000000 -> ADDR.
- ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> EXEC_R.
- CBZ 10110100xxx -> BRANCH.
- any other value -> HALT.
REQ-013 EXEC_R SHALL drive ALUOp=10, ALUSrc=0, Reg2Loc=0 and go to WB_R.
REQ-014 WB_R SHALL assert RegWrite and PCWrite (PCSrc=0), hold ALUOp=10, and go to FETCH.
REQ-015 ADDR SHALL drive ALUSrc=1 and ALUOp=00, with Reg2Loc=1 for STUR and 0 for LDUR.
- LDUR -> MEM_RD.
- STUR -> MEM_WR.
REQ-016 MEM_RD SHALL assert MemRead with ALUSrc=1.
- Stay while MemReady=0.
- Go to WB_LD in the cycle MemReady=1.
REQ-017 WB_LD SHALL assert RegWrite, MemtoReg and PCWrite (PCSrc=0) and go to FETCH.
REQ-018 MEM_WR SHALL assert MemWrite, Reg2Loc=1 and ALUSrc=1.
- PCWrite = MemReady.
- Go to FETCH when MemReady=1, else stay.
REQ-019 BRANCH SHALL drive Reg2Loc=1, ALUSrc=0, ALUOp=01 and PCWrite=1, with PCSrc=Zero for CBZ, and go to FETCH.
REQ-020 HALT SHALL hold all strobes at 0, assert Illegal, and remain in HALT until reset.
REQ-021 Latency SHALL be: R-type 4 cycles, CBZ 3 cycles, LDUR 5+N cycles, STUR 4+N cycles, where N is the number of MemReady=0 cycles spent waiting.
REQ-022 MemReady SHALL be ignored in all states other than MEM_RD and MEM_WR; Zero SHALL be ignored outside BRANCH.
REQ-023 PCWrite SHALL assert exactly once per completed instruction and never in HALT.

Reset
REQ-024 While reset is high, state SHALL be FETCH and all outputs, including IRWrite and Illegal, SHALL be 0 (asynchronously forced).
REQ-025 Reset asserted mid-operation, including during a MEM_RD or MEM_WR wait, SHALL drop MemRead and MemWrite immediately; the first rising edge after release executes FETCH.

Configuration
REQ-026 Macro CBNZ_SUPPORT_EN SHALL control CBNZ support.
- Defined: DECODE maps CBNZ 10110101xxx -> BRANCH, and BRANCH drives PCSrc = ~Zero for CBNZ.
- Undefined: CBNZ -> HALT with Illegal=1.

Verification
REQ-027 Reset, release, Op=ADD -> IRWrite in cycle 1; EXEC_R ALUOp=10 in cycle 3; RegWrite=PCWrite=1 in cycle 4; FETCH in cycle 5.
REQ-028 Op=LDUR, MemReady held 0 for 3 cycles then 1 -> MemRead high for 4 cycles, then WB_LD with RegWrite=MemtoReg=PCWrite=1; total 8 cycles.
REQ-029 Op=STUR, MemReady=1 immediately -> ADDR with Reg2Loc=1, MEM_WR with MemWrite=PCWrite=1 for one cycle; RegWrite never asserted.
REQ-030 Op=CBZ with Zero=1, then CBZ with Zero=0 -> PCSrc=1 then PCSrc=0, PCWrite=1 in both BRANCH cycles.
REQ-031 Op=11111111111 -> HALT, Illegal=1 held for 20 cycles with no strobes; reset -> Illegal=0.
REQ-032 Reset pulse during a MEM_RD wait -> MemRead=0 in the same cycle; IRWrite=1 on the first cycle after release; CBNZ with Zero=0 under CBNZ_SUPPORT_EN -> PCSrc=1.
